// File: rtl/oscilo_pkg.sv
// Shared definitions for the oscilloscope capture/readout path.
//   OSC_SAMPLE_DEPTH : default sample RAM address width (shared with the sampler)
//   readout_state_e  : readout FSM state encoding
//   SYNC0 / SYNC1    : frame sync bytes used when READOUT_FRAMING_EN is defined
package oscilo_pkg;

  localparam int OSC_SAMPLE_DEPTH = 8;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_LOAD    = 3'd4,
    ST_PRESENT = 3'd5,
    ST_CSUM    = 3'd6,
    ST_DONE    = 3'd7
  } readout_state_e;

endpackage

// File: rtl/sample_readout.sv
// sample_readout: after a capture, unrolls the circular sample RAM into time
// order (starting PRE_TRIG samples before the trigger address) and streams the
// bytes over a valid/ready byte interface. Owns the RAM read port only.
//
// Ports:
//   clk_50mhz  in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   one-cycle frame request (ignored unless idle)
//   trig_addr  in   trigger sample address, sampled with start
//   busy       out  high from accepted start until the frame finishes
//   rd_addr    out  registered RAM read address
//   rd_data    in   synchronous RAM data, valid the cycle after rd_addr is sampled
//   out_data   out  stream byte
//   out_valid  out  stream valid
//   out_ready  in   stream ready
//   frame_done out  one-cycle pulse after the last byte transfers
//   dbg_state  out  current FSM state
//
// Handshake: a byte transfers on a rising edge where out_valid && out_ready.
// Once raised, out_valid and out_data stay stable until that transfer.
//
// Build option: READOUT_FRAMING_EN adds a 0xA5,0x5A header and a trailing
// modulo-256 sum of the sample bytes.
module sample_readout
  import oscilo_pkg::*;
#(
  parameter int SAMPLE_DEPTH = OSC_SAMPLE_DEPTH,
  parameter int PRE_TRIG     = 2 ** (SAMPLE_DEPTH - 1)
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SAMPLE_DEPTH-1:0] trig_addr,
  output logic                    busy,
  output logic [SAMPLE_DEPTH-1:0] rd_addr,
  input  logic [7:0]              rd_data,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_done,
  output readout_state_e          dbg_state
);

  // Frame length needs one extra bit so the full 2**SAMPLE_DEPTH count fits.
  localparam logic [SAMPLE_DEPTH:0]   FRAME_LEN = {1'b1, {SAMPLE_DEPTH{1'b0}}};
  localparam logic [SAMPLE_DEPTH-1:0] PRE_OFS   = SAMPLE_DEPTH'(PRE_TRIG);

  readout_state_e          state_q, state_d;
  logic [SAMPLE_DEPTH-1:0] rd_addr_q, rd_addr_d;
  logic [SAMPLE_DEPTH:0]   remaining_q, remaining_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    xfer;
`ifdef READOUT_FRAMING_EN
  logic [7:0]              csum_q, csum_d;
`endif

  assign xfer = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef READOUT_FRAMING_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Subtraction wraps modulo the RAM size.
          rd_addr_d   = trig_addr - PRE_OFS;
          remaining_d = FRAME_LEN;
          busy_d      = 1'b1;
`ifdef READOUT_FRAMING_EN
          csum_d      = '0;
          out_data_d  = SYNC0;
          out_valid_d = 1'b1;
          state_d     = ST_HDR0;
`else
          state_d     = ST_WAIT;
`endif
        end
      end
`ifdef READOUT_FRAMING_EN
      ST_HDR0: begin
        if (xfer) begin
          out_data_d = SYNC1;
          state_d    = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
`endif
      // rd_addr is stable here; the RAM registers it at the end of this cycle.
      ST_WAIT: state_d = ST_LOAD;
      ST_LOAD: begin
        out_data_d  = rd_data;
        out_valid_d = 1'b1;
        remaining_d = remaining_q - 1'b1;
`ifdef READOUT_FRAMING_EN
        csum_d      = csum_q + rd_data;
`endif
        state_d     = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (xfer) begin
          if (remaining_q != '0) begin
            out_valid_d = 1'b0;
            rd_addr_d   = rd_addr_q + 1'b1;
            state_d     = ST_WAIT;
          end else begin
`ifdef READOUT_FRAMING_EN
            // csum_q already includes the last sample (added in LOAD).
            out_data_d  = csum_q;
            state_d     = ST_CSUM;
`else
            out_valid_d = 1'b0;
            state_d     = ST_DONE;
`endif
          end
        end
      end
`ifdef READOUT_FRAMING_EN
      ST_CSUM: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          state_d     = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef READOUT_FRAMING_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef READOUT_FRAMING_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign rd_addr    = rd_addr_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = (state_q == ST_DONE);
  assign dbg_state  = state_q;

endmodule
